// File: rtl/rx_header_decode_if.sv
// Header-decoder bus: correlator/link-controller inputs and decoded header outputs.
// master = surrounding baseband logic, slave = rx_header_decode.
interface rx_header_decode_if;
  logic       p_1us;
  logic       rx_header_st_p;
  logic       rx_abort;
  logic       rxbit;
  logic       rx_whiten_en;
  logic [6:0] whitening_init;
  logic [7:0] hec_init;
  logic [2:0] regi_mylt_address;

  logic       hdr_busy;
  logic       hdr_valid_p;
  logic [2:0] hdr_lt_addr;
  logic [3:0] hdr_type;
  logic       hdr_flow;
  logic       hdr_arqn;
  logic       hdr_seqn;
  logic       hec_ok;
  logic       lt_addressed;
  logic       rxispoll;
  logic [4:0] fec_corr_cnt;

  modport master (
    output p_1us, rx_header_st_p, rx_abort, rxbit, rx_whiten_en, whitening_init, hec_init,
           regi_mylt_address,
    input  hdr_busy, hdr_valid_p, hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn, hdr_seqn, hec_ok,
           lt_addressed, rxispoll, fec_corr_cnt
  );

  modport slave (
    input  p_1us, rx_header_st_p, rx_abort, rxbit, rx_whiten_en, whitening_init, hec_init,
           regi_mylt_address,
    output hdr_busy, hdr_valid_p, hdr_lt_addr, hdr_type, hdr_flow, hdr_arqn, hdr_seqn, hec_ok,
           lt_addressed, rxispoll, fec_corr_cnt
  );
endinterface

// File: rtl/rx_header_decode.sv
// Serial baseband packet-header receiver: FEC 1/3 majority vote, de-whitening and HEC check,
// presenting the decoded header fields with a one-cycle valid pulse.
module rx_header_decode #(
  parameter int unsigned HDR_BITS = 54,
  parameter logic [7:0]  HEC_POLY = 8'hA7
) (
  input logic               clk_6M,
  input logic               rstz,
  rx_header_decode_if.slave bus
);

  localparam logic [4:0] LastIdx = 5'(HDR_BITS / 3 - 1);
  localparam logic [4:0] NumInfo = 5'd10;

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e     state_q, state_d;
  logic       whiten_en_q;
  logic [6:0] wht_q, wht_next;
  logic [7:0] hec_q, hec_next;
  logic [1:0] tri_cnt_q;
  logic [1:0] tri_q;
  logic [4:0] info_idx_q;
  logic       match_q;
  logic [9:0] info_q;
  logic [4:0] fec_cnt_q;

  logic [2:0] lt_q;
  logic [3:0] type_q;
  logic       flow_q, arqn_q, seqn_q;
  logic       hec_ok_q, lt_addr_q, poll_q;

  logic start, strobe, third, last;
  logic maj, disagree, d, hec_fb, hec_bit_ok, hec_ok_d, lt_match_d;

  always_comb begin
    start      = bus.rx_header_st_p & ~bus.rx_abort;
    // A restart or abort wins over a bit strobe in the same cycle.
    strobe     = (state_q == StCollect) & bus.p_1us & ~bus.rx_abort & ~bus.rx_header_st_p;
    third      = strobe & (tri_cnt_q == 2'd2);
    last       = (info_idx_q == LastIdx);
    maj        = (tri_q[1] & tri_q[0]) | (tri_q[1] & bus.rxbit) | (tri_q[0] & bus.rxbit);
    disagree   = ~((tri_q[1] == tri_q[0]) & (tri_q[0] == bus.rxbit));
    d          = maj ^ (wht_q[6] & whiten_en_q);
    hec_fb     = hec_q[7] ^ d;
    hec_next   = {hec_q[6:0], 1'b0} ^ ({8{hec_fb}} & HEC_POLY);
    // Received HEC bit k is compared against hec_q[7-k]; hec_q is frozen after info bit 9.
    hec_bit_ok = (d == hec_q[3'(LastIdx - info_idx_q)]);
    hec_ok_d   = match_q & hec_bit_ok;
    lt_match_d = hec_ok_d & (info_q[2:0] == bus.regi_mylt_address);
    wht_next    = {wht_q[5:0], wht_q[6]};
    wht_next[4] = wht_q[3] ^ wht_q[6];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (third && last) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (bus.rx_abort) begin
      state_d = StIdle;
    end else if (bus.rx_header_st_p) begin
      state_d = StCollect;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      whiten_en_q <= 1'b0;
      wht_q       <= '0;
      hec_q       <= '0;
      tri_cnt_q   <= '0;
      tri_q       <= '0;
      info_idx_q  <= '0;
      match_q     <= 1'b0;
      info_q      <= '0;
      fec_cnt_q   <= '0;
      lt_q        <= '0;
      type_q      <= '0;
      flow_q      <= 1'b0;
      arqn_q      <= 1'b0;
      seqn_q      <= 1'b0;
      hec_ok_q    <= 1'b0;
      lt_addr_q   <= 1'b0;
      poll_q      <= 1'b0;
    end else if (start) begin
      whiten_en_q <= bus.rx_whiten_en;
      wht_q       <= bus.whitening_init;
      hec_q       <= bus.hec_init;
      tri_cnt_q   <= '0;
      tri_q       <= '0;
      info_idx_q  <= '0;
      match_q     <= 1'b1;
      fec_cnt_q   <= '0;
    end else if (strobe) begin
      if (third) begin
        tri_cnt_q  <= '0;
        wht_q      <= wht_next;
        info_idx_q <= info_idx_q + 5'd1;
        if (disagree) fec_cnt_q <= fec_cnt_q + 5'd1;
        if (info_idx_q < NumInfo) begin
          info_q <= {d, info_q[9:1]};
          hec_q  <= hec_next;
        end else if (!hec_bit_ok) begin
          match_q <= 1'b0;
        end
        if (last) begin
          lt_q      <= info_q[2:0];
          type_q    <= info_q[6:3];
          flow_q    <= info_q[7];
          arqn_q    <= info_q[8];
          seqn_q    <= info_q[9];
          hec_ok_q  <= hec_ok_d;
          lt_addr_q <= lt_match_d;
          poll_q    <= lt_match_d & (info_q[6:3] == 4'h1);
        end
      end else begin
        tri_q     <= {tri_q[0], bus.rxbit};
        tri_cnt_q <= tri_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    bus.hdr_busy     = (state_q == StCollect);
    bus.hdr_valid_p  = (state_q == StDone);
    bus.hdr_lt_addr  = lt_q;
    bus.hdr_type     = type_q;
    bus.hdr_flow     = flow_q;
    bus.hdr_arqn     = arqn_q;
    bus.hdr_seqn     = seqn_q;
    bus.hec_ok       = hec_ok_q;
    bus.lt_addressed = lt_addr_q;
    bus.rxispoll     = poll_q;
    bus.fec_corr_cnt = fec_cnt_q;
  end

endmodule

// File: tb/tb_rx_header_decode.sv
// Directed bench for rx_header_decode: builds over-the-air headers with a small encoder model
// and checks decoded fields, HEC status, FEC counts and pulse timing.
module tb_rx_header_decode;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  always #5 clk_6M = ~clk_6M;

  rx_header_decode_if bus ();

  rx_header_decode dut (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .bus    (bus)
  );

  always @(negedge clk_6M) if (bus.hdr_valid_p === 1'b1) valid_cnt++;

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder model: 10 info bits LSB first, 8 HEC bits MSB first, whitened, each bit tripled.
  function automatic logic [53:0] build_raw(input logic [2:0] lt, input logic [3:0] ty,
                                            input logic fl, input logic ar, input logic sq,
                                            input logic en, input logic [6:0] wi,
                                            input logic [7:0] hi);
    logic [17:0] info;
    logic [7:0]  h;
    logic [6:0]  w, nw;
    logic        fb, b;
    logic [53:0] raw;
    info[2:0] = lt;
    info[6:3] = ty;
    info[7]   = fl;
    info[8]   = ar;
    info[9]   = sq;
    h = hi;
    for (int i = 0; i < 10; i++) begin
      fb = h[7] ^ info[i];
      h  = {h[6:0], 1'b0};
      if (fb) h = h ^ 8'hA7;
    end
    for (int k = 0; k < 8; k++) info[10+k] = h[7-k];
    w = wi;
    raw = '0;
    for (int i = 0; i < 18; i++) begin
      b = info[i] ^ (en & w[6]);
      raw[3*i +: 3] = {3{b}};
      nw = {w[5:0], w[6]};
      nw[4] = w[3] ^ w[6];
      w = nw;
    end
    return raw;
  endfunction

  task automatic start_hdr(input logic en, input logic [6:0] wi, input logic [7:0] hi,
                           input logic junk_strobe);
    bus.rx_whiten_en   = en;
    bus.whitening_init = wi;
    bus.hec_init       = hi;
    bus.rx_header_st_p = 1'b1;
    bus.p_1us          = junk_strobe;
    bus.rxbit          = 1'b1;
    tick();
    bus.rx_header_st_p = 1'b0;
    bus.p_1us          = 1'b0;
  endtask

  task automatic send_bits(input logic [53:0] raw, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      repeat (2) tick();
      bus.p_1us = 1'b1;
      bus.rxbit = raw[i];
      tick();
      bus.p_1us = 1'b0;
    end
  endtask

  task automatic run_hdr(input string tag, input logic [53:0] raw, input logic en,
                         input logic [6:0] wi, input logic [7:0] hi, input logic junk_strobe);
    int v0;
    start_hdr(en, wi, hi, junk_strobe);
    chk({tag, "_busy"}, 8'(bus.hdr_busy), 8'd1);
    v0 = valid_cnt;
    send_bits(raw, 0, 54);
    chk({tag, "_valid_latency"}, 8'(bus.hdr_valid_p), 8'd1);
    chk({tag, "_busy_done"}, 8'(bus.hdr_busy), 8'd0);
    tick();
    chk({tag, "_valid_width"}, 8'(bus.hdr_valid_p), 8'd0);
    chk({tag, "_valid_count"}, 8'(valid_cnt - v0), 8'd1);
  endtask

  task automatic chk_fields(input string tag, input logic [2:0] lt, input logic [3:0] ty,
                            input logic fl, input logic ar, input logic sq, input logic hok,
                            input logic la, input logic poll, input logic [4:0] fec);
    chk({tag, "_lt"}, 8'(bus.hdr_lt_addr), 8'(lt));
    chk({tag, "_type"}, 8'(bus.hdr_type), 8'(ty));
    chk({tag, "_flags"}, 8'({bus.hdr_flow, bus.hdr_arqn, bus.hdr_seqn}), 8'({fl, ar, sq}));
    chk({tag, "_hec_ok"}, 8'(bus.hec_ok), 8'(hok));
    chk({tag, "_lt_addressed"}, 8'(bus.lt_addressed), 8'(la));
    chk({tag, "_rxispoll"}, 8'(bus.rxispoll), 8'(poll));
    chk({tag, "_fec"}, 8'(bus.fec_corr_cnt), 8'(fec));
  endtask

  initial begin
    logic [53:0] raw_a, raw_b, mask;
    int v0;
    bus.p_1us = 0; bus.rx_header_st_p = 0; bus.rx_abort = 0; bus.rxbit = 0;
    bus.rx_whiten_en = 0; bus.whitening_init = '0; bus.hec_init = '0;
    bus.regi_mylt_address = 3'd3;

    repeat (3) tick();
    chk("rst_busy", 8'(bus.hdr_busy), 8'd0);
    chk("rst_valid", 8'(bus.hdr_valid_p), 8'd0);
    chk_fields("rst", 3'd0, 4'h0, 0, 0, 0, 0, 0, 0, 5'd0);
    rstz = 1'b1;
    tick();

    // p_1us outside COLLECT does nothing
    bus.p_1us = 1'b1;
    repeat (3) tick();
    bus.p_1us = 1'b0;
    chk("idle_strobe_busy", 8'(bus.hdr_busy), 8'd0);

    // Clean header, no whitening
    raw_a = build_raw(3'd3, 4'h4, 1, 0, 1, 0, 7'h00, 8'h00);
    run_hdr("clean", raw_a, 0, 7'h00, 8'h00, 0);
    chk_fields("clean", 3'd3, 4'h4, 1, 0, 1, 1, 1, 0, 5'd0);

    // Same header whitened
    raw_a = build_raw(3'd3, 4'h4, 1, 0, 1, 1, 7'h55, 8'h00);
    run_hdr("whiten", raw_a, 1, 7'h55, 8'h00, 0);
    chk_fields("whiten", 3'd3, 4'h4, 1, 0, 1, 1, 1, 0, 5'd0);

    // One flipped bit in every triple
    mask = '0;
    for (int i = 0; i < 18; i++) mask[3*i + (i % 3)] = 1'b1;
    raw_a = build_raw(3'd3, 4'h4, 1, 0, 1, 0, 7'h00, 8'h00) ^ mask;
    run_hdr("fec18", raw_a, 0, 7'h00, 8'h00, 0);
    chk_fields("fec18", 3'd3, 4'h4, 1, 0, 1, 1, 1, 0, 5'd18);

    // Two flips in the TYPE[0] triple defeat the vote
    raw_a = build_raw(3'd3, 4'h4, 1, 0, 1, 0, 7'h00, 8'h00) ^ (54'h3 << 9);
    run_hdr("badvote", raw_a, 0, 7'h00, 8'h00, 0);
    chk_fields("badvote", 3'd3, 4'h5, 1, 0, 1, 0, 0, 0, 5'd1);

    // POLL addressed to us, nonzero HEC seed
    raw_a = build_raw(3'd3, 4'h1, 0, 1, 0, 0, 7'h00, 8'h9C);
    run_hdr("poll", raw_a, 0, 7'h00, 8'h9C, 0);
    chk_fields("poll", 3'd3, 4'h1, 0, 1, 0, 1, 1, 1, 5'd0);
    bus.regi_mylt_address = 3'd5;
    run_hdr("poll_other", raw_a, 0, 7'h00, 8'h9C, 0);
    chk_fields("poll_other", 3'd3, 4'h1, 0, 1, 0, 1, 0, 0, 5'd0);
    bus.regi_mylt_address = 3'd3;

    // Restart after 20 bits of a noisy header A; only header B is reported
    mask = '0;
    for (int i = 0; i < 6; i++) mask[3*i] = 1'b1;
    raw_a = build_raw(3'd6, 4'hA, 0, 0, 0, 0, 7'h00, 8'h11) ^ mask;
    raw_b = build_raw(3'd3, 4'h1, 1, 1, 1, 1, 7'h2A, 8'h3B);
    v0 = valid_cnt;
    start_hdr(0, 7'h00, 8'h11, 0);
    send_bits(raw_a, 0, 20);
    run_hdr("restart", raw_b, 1, 7'h2A, 8'h3B, 0);
    chk("restart_total_pulses", 8'(valid_cnt - v0), 8'd1);
    chk_fields("restart", 3'd3, 4'h1, 1, 1, 1, 1, 1, 1, 5'd0);

    // Abort mid-header: no pulse, fields held
    raw_a = build_raw(3'd2, 4'h9, 0, 1, 1, 0, 7'h00, 8'h00);
    v0 = valid_cnt;
    start_hdr(0, 7'h00, 8'h00, 0);
    send_bits(raw_a, 0, 30);
    bus.rx_abort = 1'b1;
    tick();
    bus.rx_abort = 1'b0;
    chk("abort_busy", 8'(bus.hdr_busy), 8'd0);
    send_bits(raw_a, 30, 24);
    repeat (3) tick();
    chk("abort_pulses", 8'(valid_cnt - v0), 8'd0);
    chk("abort_hold_lt", 8'(bus.hdr_lt_addr), 8'd3);

    // Abort wins over a same-cycle start
    bus.rx_abort = 1'b1;
    bus.rx_header_st_p = 1'b1;
    tick();
    bus.rx_abort = 1'b0;
    bus.rx_header_st_p = 1'b0;
    chk("abort_vs_start_busy", 8'(bus.hdr_busy), 8'd0);

    // Strobe coincident with the start pulse is not bit 0
    raw_a = build_raw(3'd5, 4'h3, 1, 1, 0, 0, 7'h00, 8'h47);
    run_hdr("coinc", raw_a, 0, 7'h00, 8'h47, 1);
    chk_fields("coinc", 3'd5, 4'h3, 1, 1, 0, 1, 0, 0, 5'd0);

    // Asynchronous reset mid-header
    v0 = valid_cnt;
    start_hdr(0, 7'h00, 8'h00, 0);
    send_bits(raw_a, 0, 15);
    #2;
    rstz = 1'b0;
    #1;
    chk("arst_busy", 8'(bus.hdr_busy), 8'd0);
    chk("arst_lt", 8'(bus.hdr_lt_addr), 8'd0);
    chk("arst_hec_ok", 8'(bus.hec_ok), 8'd0);
    tick();
    rstz = 1'b1;
    send_bits(raw_a, 15, 39);
    repeat (3) tick();
    chk("arst_pulses", 8'(valid_cnt - v0), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_header_decode.md
Name: rx_header_decode

Overview:
- Receive-side counterpart of the baseband header encoder.
- Takes the 54-bit over-the-air packet header serially on rxbit.
- Applies FEC 1/3 majority decoding, de-whitens, and checks the HEC.
- Presents LT_ADDR, TYPE, FLOW, ARQN and SEQN to the link controller with a one-cycle valid pulse. Sits between the access-code correlator (which supplies the header start pulse) and the payload bit processor.

Parameters:
HDR_BITS, 54, raw header bits on air (18 info bits x3)
HEC_POLY, 8'hA7, HEC LFSR taps x^7+x^5+x^2+x+1 (x^8 implicit)

Ports:
clk_6M  input  1  system clock, 6 MHz
rstz  input  1  asynchronous active-low reset
p_1us  input  1  bit strobe; rxbit sampled only when high
rx_header_st_p  input  1  one-cycle pulse; the next p_1us carries header bit 0
rx_abort  input  1  synchronous abort; return to IDLE
rxbit  input  1  demodulated serial bit
rx_whiten_en  input  1  enable de-whitening, sampled at start
whitening_init  input  7  whitening LFSR seed (from CLK[6:1]/Xir), sampled at start
hec_init  input  8  HEC seed (UAP/DCI), sampled at start
regi_mylt_address  input  3  own LT_ADDR for match
hdr_busy  output  1  high in COLLECT
hdr_valid_p  output  1  one-cycle pulse, header fields updated
hdr_lt_addr  output  3  decoded LT_ADDR
hdr_type  output  4  decoded TYPE
hdr_flow / hdr_arqn / hdr_seqn  output  1 each  decoded flags
hec_ok  output  1  HEC matched (valid with hdr_valid_p, held)
lt_addressed  output  1  hec_ok & (hdr_lt_addr==regi_mylt_address)
rxispoll  output  1  lt_addressed & hdr_type==4'h1
fec_corr_cnt  output  5  triples with disagreement in last header (0..18)

Behaviour:
- Reset: all outputs and registers 0; FSM IDLE.
- FSM states:
  - IDLE: rx_header_st_p -> COLLECT. Latch whitening_init, hec_init, rx_whiten_en. Clear tri_cnt (2b), info_idx (5b), vote accumulator, fec_corr_cnt.
  - COLLECT: on each p_1us, shift rxbit into the 3-bit triple register and advance tri_cnt.
  - On the 3rd bit of a triple:
    - maj = majority of the 3 bits.
    - If the 3 bits are not all equal, fec_corr_cnt += 1 (saturates at 18 by construction).
    - d = maj ^ (w[6] & whiten_en).
    - The whitening LFSR steps: w <= {w[5:0], w[6]}, with w[4] <= w[3]^w[6].
    - info_idx += 1.
  - Info bits 0..9 (LSB first: LT_ADDR[0..2], TYPE[0..3], FLOW, ARQN, SEQN):
    - Stored into field registers.
    - HEC LFSR: fb = hec[7]^d; hec <= {hec[6:0],1'b0} ^ ({8{fb}} & HEC_POLY).
  - Info bits 10..17: received HEC bit k (k=0..7) compared with hec[7-k] of the register frozen after bit 9. Any mismatch clears the internal match flag (set at start).
  - After info bit 17 -> DONE.
  - DONE: for one cycle, drive hdr_valid_p=1. Update the output field registers, hec_ok, lt_addressed, rxispoll. Then -> IDLE.
- Latency: hdr_valid_p asserts exactly one clk_6M after the p_1us carrying raw bit 53.
- Hold: output fields hold until the next DONE; they are not cleared at start. hdr_busy=1 only in COLLECT.
- rx_header_st_p in COLLECT or DONE: restart as from IDLE, reloading seeds. The partial header is discarded; no hdr_valid_p.
- rx_abort: -> IDLE next cycle; no hdr_valid_p. rx_abort has priority over a same-cycle rx_header_st_p.
- Same-cycle p_1us and rx_header_st_p in IDLE: that strobe is not sampled; bit 0 is the next p_1us.
- p_1us only matters in COLLECT; it is ignored elsewhere.
- Asynchronous reset mid-header: immediate return to reset state.

Test Plan:
- Clean header, whitening off, hec_init=8'h00, LT=3, TYPE=4'h4, FLOW=1, ARQN=0, SEQN=1, HEC from golden model -> hdr_valid_p once, 1 cycle after strobe 54. Fields match, hec_ok=1, fec_corr_cnt=0.
- Same header with rx_whiten_en=1, whitening_init=7'h55, tx pre-whitened by model -> identical fields, hec_ok=1.
- One flipped bit in each of the 18 triples -> fields correct, hec_ok=1, fec_corr_cnt=18.
- Two flipped bits in the TYPE[0] triple -> TYPE[0] inverted, hec_ok=0, lt_addressed=0, rxispoll=0.
- regi_mylt_address=3, TYPE=4'h1, clean header -> lt_addressed=1, rxispoll=1. With regi_mylt_address=5 -> both 0.
- rx_header_st_p re-pulsed after 20 bits, then full header -> exactly one hdr_valid_p, decoded from the second header. rx_abort or rstz low mid-header -> no pulse, hdr_busy=0.
